// File: rtl/alu_pipe.sv
// alu_pipe: registered, parametrised ALU with valid/ready handshakes.
// Sits between the register file / control sequencer and the accumulator
// write-back of the 8-bit computer datapath.
//
// Operations (op): 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 NOT,
// 8 SHL, 9 SHR, 10 MUL (iterative shift-add), 11-15 illegal.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept a request this cycle
//   op         opcode
//   in_a/in_b  operands
//   out_valid  result/flags valid
//   out_ready  consumer accepts result
//   result     result (low half of the product for MUL)
//   result_hi  high half of the MUL product, 0 for other ops
//   flags      {err, v, n, z, c}, registered together with result
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  localparam int MSB = WIDTH - 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                 carry_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 cnt_last;

  logic                 accept;
  logic                 pop;

  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;
  logic                 alu_err;
  logic                 alu_sets_c;
  logic [4:0]           alu_flags;

  assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // The multiplicand shifts left and the multiplier shifts right each
  // iteration, so bit[counter] of the original multiplier is always at bit 0.
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

  // Single-cycle operations. Add/sub run at WIDTH+1 bits so the top bit is
  // the carry (add) or the borrow (sub).
  always_comb begin
    sum        = '0;
    alu_res    = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_err    = 1'b0;
    alu_sets_c = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        sum = {1'b0, in_a} + {1'b0, in_b}
              + ((op == OP_ADC) ? {{WIDTH{1'b0}}, carry_q} : '0);
        alu_res    = sum[WIDTH-1:0];
        alu_c      = sum[WIDTH];
        alu_v      = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_a[MSB]);
        alu_sets_c = 1'b1;
      end
      OP_SUB, OP_SBB: begin
        sum = {1'b0, in_a} - {1'b0, in_b}
              - ((op == OP_SBB) ? {{WIDTH{1'b0}}, carry_q} : '0);
        alu_res    = sum[WIDTH-1:0];
        alu_c      = sum[WIDTH];
        alu_v      = (in_a[MSB] != in_b[MSB]) && (sum[MSB] != in_a[MSB]);
        alu_sets_c = 1'b1;
      end
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_NOT: alu_res = ~in_a;
      OP_SHL: begin
        alu_res    = {in_a[WIDTH-2:0], 1'b0};
        alu_c      = in_a[MSB];
        alu_sets_c = 1'b1;
      end
      OP_SHR: begin
        alu_res    = {1'b0, in_a[WIDTH-1:1]};
        alu_c      = in_a[0];
        alu_sets_c = 1'b1;
      end
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
    alu_flags = {alu_err, alu_v, alu_res[MSB], (alu_res == '0), alu_c};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && (op == OP_MUL)) state_d = S_BUSY;
      S_BUSY: if (cnt_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers, stored carry and multiplier datapath. A MUL is only
  // accepted when the output slot is empty or being popped, so out_valid is
  // always low while BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
    end else if (state_q == S_IDLE) begin
      if (accept) begin
        if (op == OP_MUL) begin
          mcand_q   <= {{WIDTH{1'b0}}, in_a};
          mplier_q  <= in_b;
          acc_q     <= '0;
          cnt_q     <= '0;
          out_valid <= 1'b0;
        end else begin
          result    <= alu_res;
          result_hi <= '0;
          flags     <= alu_flags;
          out_valid <= 1'b1;
          if (alu_sets_c) carry_q <= alu_c;
        end
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end else begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (cnt_last) begin
        result    <= acc_next[WIDTH-1:0];
        result_hi <= acc_next[2*WIDTH-1:WIDTH];
        flags     <= {1'b0, 1'b0, acc_next[MSB], (acc_next == '0), 1'b0};
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=8). A transaction-level
// model computes results with plain integer arithmetic; a negedge process
// compares the DUT against it every cycle, and directed scenarios pin
// hand-computed values.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [4:0]   flags;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // Model state
  int m_c = 0, m_ov = 0, m_res = 0, m_hi = 0, m_flags = 0, m_busy = 0;
  int p_res = 0, p_hi = 0, p_flags = 0;
  bit m_accepted = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int model_in_ready();
    return (m_busy == 0 && (m_ov == 0 || out_ready == 1'b1)) ? 1 : 0;
  endfunction

  // Result and flags of one operation from plain integer arithmetic.
  task automatic model_op(input int o, input int a, input int b,
                          output int r, output int h, output int f,
                          output int nc, output bit upd);
    int s, sa, sb, sr, err, v, c, z, n;
    longint p;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0; h = 0; err = 0; v = 0; c = 0; upd = 0; s = 0; sr = 0;
    p = longint'(a) * longint'(b);
    case (o)
      0, 1: begin
        s  = a + b + ((o == 1) ? m_c : 0);
        sr = sa + sb + ((o == 1) ? m_c : 0);
        r = s & 255; c = (s > 255) ? 1 : 0;
        v = (sr > 127 || sr < -128) ? 1 : 0; upd = 1;
      end
      2, 3: begin
        s  = a - b - ((o == 3) ? m_c : 0);
        sr = sa - sb - ((o == 3) ? m_c : 0);
        r = s & 255; c = (s < 0) ? 1 : 0;
        v = (sr > 127 || sr < -128) ? 1 : 0; upd = 1;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = 255 - a;
      8: begin r = (a * 2) & 255; c = a / 128; upd = 1; end
      9: begin r = a / 2; c = a % 2; upd = 1; end
      10: begin r = int'(p % 256); h = int'(p / 256); end
      default: err = 1;
    endcase
    z = (o == 10) ? ((p == 0) ? 1 : 0) : ((r == 0) ? 1 : 0);
    n = (r >= 128) ? 1 : 0;
    f = err * 16 + v * 8 + n * 4 + z * 2 + c;
    nc = c;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    int r, h, f, nc;
    bit upd;
    m_accepted = 0;
    if (rst_n !== 1'b1) begin
      m_c = 0; m_ov = 0; m_res = 0; m_hi = 0; m_flags = 0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_res = p_res; m_hi = p_hi; m_flags = p_flags; m_ov = 1;
      end
    end else if (in_valid && model_in_ready() == 1) begin
      m_accepted = 1;
      model_op(int'(op), int'(in_a), int'(in_b), r, h, f, nc, upd);
      if (op == 4'd10) begin
        p_res = r; p_hi = h; p_flags = f; m_busy = W; m_ov = 0;
      end else begin
        m_res = r; m_hi = h; m_flags = f; m_ov = 1;
        if (upd) m_c = nc;
      end
    end else if (m_ov == 1 && out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    in_valid = 1'b1; op = o; in_a = a; in_b = b;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (m_accepted) break;
    end
    if (!m_accepted) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: got 0 expected 1 at %0t", $time);
    end
    in_valid = 1'b0;
    op = 4'($urandom); in_a = W'($urandom); in_b = W'($urandom);
  endtask

  task automatic waitResult();
    for (int k = 0; k < 20 && m_ov == 0; k++) tick();
    if (m_ov == 0) begin
      checks++; errors++;
      $display("[TB] FAIL result_timeout: got 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic expectResult(input string name, input int r, input int h,
                              input int f);
    waitResult();
    checkOutput({name, "_valid"}, out_valid, 1);
    checkOutput({name, "_res"}, result, r);
    checkOutput({name, "_hi"}, result_hi, h);
    checkOutput({name, "_flags"}, flags, f);
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("cyc_in_ready", in_ready, model_in_ready());
        checkOutput("cyc_out_valid", out_valid, m_ov);
        if (m_ov == 1) begin
          checkOutput("cyc_result", result, m_res);
          checkOutput("cyc_result_hi", result_hi, m_hi);
          checkOutput("cyc_flags", flags, m_flags);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b1;
    tick();
    check_en = 1;
    tick(); tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_flags", flags, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Basic add and carry out
    applyStimulus(4'd0, 8'd10, 8'd20);  expectResult("add", 30, 0, 5'b00000);
    applyStimulus(4'd0, 8'd255, 8'd1);  expectResult("add_c", 0, 0, 5'b00011);
    // Stored carry consumption
    applyStimulus(4'd1, 8'd0, 8'd0);    expectResult("adc", 1, 0, 5'b00000);
    applyStimulus(4'd2, 8'd0, 8'd1);    expectResult("sub_b", 255, 0, 5'b00101);
    applyStimulus(4'd3, 8'd5, 8'd3);    expectResult("sbb", 1, 0, 5'b00000);
    // Subtraction flags and illegal opcode leaving C untouched
    applyStimulus(4'd2, 8'h80, 8'h01);  expectResult("sub_v", 8'h7F, 0, 5'b01000);
    applyStimulus(4'd2, 8'd50, 8'd100); expectResult("sub_n", 206, 0, 5'b00101);
    applyStimulus(4'd12, 8'd9, 8'd9);   expectResult("illegal", 0, 0, 5'b10010);
    applyStimulus(4'd1, 8'd0, 8'd0);    expectResult("adc_keep", 1, 0, 5'b00000);

    // Multiply latency: busy for W cycles after the accept
    applyStimulus(4'd10, 8'd200, 8'd3);
    for (int i = 1; i <= W; i++) begin
      checkOutput("mul_busy_ready", in_ready, 0);
      checkOutput("mul_busy_valid", out_valid, 0);
      tick();
    end
    checkOutput("mul_done_valid", out_valid, 1);
    expectResult("mul", 8'h58, 8'h02, 5'b00000);
    applyStimulus(4'd10, 8'd0, 8'h77);  expectResult("mul_z", 0, 0, 5'b00010);

    // Backpressure, then pop and accept on the same edge
    tick();
    out_ready = 1'b0;
    applyStimulus(4'd0, 8'd1, 8'd2);
    in_valid = 1'b1; op = 4'd6; in_a = 8'hF0; in_b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_result", result, 3);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("xor_valid", out_valid, 1);
    checkOutput("xor_result", result, 8'h0F);
    checkOutput("xor_flags", flags, 5'b00000);

    // Reset in the middle of a multiply, with C=1 beforehand
    applyStimulus(4'd2, 8'd0, 8'd1);    expectResult("pre_rst", 255, 0, 5'b00101);
    applyStimulus(4'd10, 8'd7, 8'd9);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checkOutput("mrst_out_valid", out_valid, 0);
    checkOutput("mrst_flags", flags, 0);
    checkOutput("mrst_result", result, 0);
    checkOutput("mrst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    applyStimulus(4'd1, 8'd1, 8'd1);    expectResult("adc_after_rst", 2, 0, 5'b00000);

    // Randomised traffic checked by the cycle compare process
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = ($urandom_range(0, 99) < 8) ? 4'($urandom_range(11, 15))
                                              : 4'($urandom_range(0, 10));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
